// File: rtl/mips_muldiv_if.sv
// Handshake and result bus between the EX-stage control and the mul/div unit.
// master: pipeline side driving operations; slave: the mips_muldiv unit.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srca, srcb, flush, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, flush, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers, one bit per cycle.
// op: 00 multu, 01 mult, 10 divu, 11 div.
// Optional feature macro MULDIV_SIGNED_EN: compiles in signed mult/div
// (abs-value operand conditioning and sign fix-up). Without it op[0] is
// ignored and everything runs unsigned with the same latency.
module mips_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    mips_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_nx;
    logic [CNTW-1:0]    cnt;
    logic [WIDTH-1:0]   mag_a, mag_b;   // operand magnitudes
    logic [WIDTH-1:0]   sh;             // multiplier bits (mul) / dividend bits (div)
    logic [2*WIDTH-1:0] acc;            // product, or {remainder, quotient}
    logic               is_div, neg_a, neg_b;

    logic               in_neg_a, in_neg_b;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;
    logic               start_ok;

    // a flush in IDLE cancels a start presented in the same cycle
    assign start_ok = bus.start && !bus.flush;
    assign bus.busy = (state != IDLE);

`ifdef MULDIV_SIGNED_EN
    assign in_neg_a = bus.op[0] & bus.srca[WIDTH-1];
    assign in_neg_b = bus.op[0] & bus.srcb[WIDTH-1];
    assign in_mag_a = in_neg_a ? -bus.srca : bus.srca;
    assign in_mag_b = in_neg_b ? -bus.srcb : bus.srcb;
    // negate product/quotient on differing signs; remainder follows srca
    assign prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    assign quo_fix  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
    logic unused_sign;
    assign in_neg_a    = 1'b0;
    assign in_neg_b    = 1'b0;
    assign in_mag_a    = bus.srca;
    assign in_mag_b    = bus.srcb;
    assign prod_fix    = acc;
    assign quo_fix     = acc[WIDTH-1:0];
    assign rem_fix     = acc[2*WIDTH-1:WIDTH];
    assign unused_sign = bus.op[0] | neg_a | neg_b;
`endif

    // one shift-add / restoring shift-subtract step per RUN cycle
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (sh[0] ? {1'b0, mag_a} : '0);
        div_trial = {acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]};
        div_diff  = div_trial - {1'b0, mag_b};
    end

    // result select; divide by zero forces an all-ones quotient, and the
    // remainder path already reproduces the original dividend in that case
    always_comb begin
        hi_res = prod_fix[2*WIDTH-1:WIDTH];
        lo_res = prod_fix[WIDTH-1:0];
        if (is_div) begin
            hi_res = rem_fix;
            lo_res = (mag_b == '0) ? '1 : quo_fix;
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state decode; flush aborts RUN/FIN without committing
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = RUN;
            RUN:     if (bus.flush) state_nx = IDLE;
                     else if (cnt == CNTW'(WIDTH - 1)) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // operand latch, iteration datapath, HI/LO writes and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            sh       <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= (state == FIN) && !bus.flush;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mag_a  <= in_mag_a;
                        mag_b  <= in_mag_b;
                        sh     <= bus.op[1] ? in_mag_a : in_mag_b;
                        neg_a  <= in_neg_a;
                        neg_b  <= in_neg_b;
                        is_div <= bus.op[1];
                        acc    <= '0;
                        cnt    <= '0;
                    end else if (!bus.start) begin
                        if (bus.mthi) bus.hi <= bus.wdata;
                        if (bus.mtlo) bus.lo <= bus.wdata;
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        if (is_div) begin
                            acc[2*WIDTH-1:WIDTH] <= div_diff[WIDTH] ? div_trial[WIDTH-1:0]
                                                                     : div_diff[WIDTH-1:0];
                            acc[WIDTH-1:0]       <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
                            sh                   <= {sh[WIDTH-2:0], 1'b0};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                            sh  <= {1'b0, sh[WIDTH-1:1]};
                        end
                        if (cnt != CNTW'(WIDTH - 1)) cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    if (!bus.flush) begin
                        bus.hi <= hi_res;
                        bus.lo <= lo_res;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed-vector bench for mips_muldiv (WIDTH=32), signed or unsigned build.
module tb_mips_muldiv;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_muldiv_if #(.WIDTH(W)) bus ();

    mips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // present an op at the negedge, let it be sampled, drop start 1ns after E0
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srca  = a;
        bus.srcb  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // count edges until done, and samples with busy high (including post-E0)
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        chk("done_seen", 64'(bus.done), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int lat, bcnt;
        launch(op, a, b);
        wait_done(lat, bcnt);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    endtask

    initial begin
        int lat, bcnt;
        bit seen;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.srca  = '0;
        bus.srcb  = '0;
        bus.flush = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi",   64'(bus.hi),   64'd0);
        chk("rst_lo",   64'(bus.lo),   64'd0);

        // multu max x max, with latency and busy length
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        chk("multu_lat",  64'(lat),  64'd33);
        chk("multu_busy", 64'(bcnt), 64'd33);
        chk("multu_hi",   64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo",   64'(bus.lo), 64'h0000_0000_0000_0001);
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(bus.done), 64'd0);

`ifdef MULDIV_SIGNED_EN
        run_op("mult",  2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu",  2'b10, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("div",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ov",2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
`else
        run_op("mult",  2'b01, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1);
        run_op("divu",  2'b10, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("div",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'h1,         32'h7FFF_FFFC);
        run_op("div_ov",2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
`endif
        run_op("div0", 2'b10, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);

        // preload HI/LO, then abort a multiply at iteration 10
        @(negedge clk);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hAAAA;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h5555;
        @(negedge clk);
        bus.mtlo  = 1'b0;
        chk("pre_hi", 64'(bus.hi), 64'hAAAA);
        chk("pre_lo", 64'(bus.lo), 64'h5555);
        launch(2'b00, 32'd3, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        seen = bus.done;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("flush_nodone", 64'(seen), 64'd0);
        chk("flush_hi", 64'(bus.hi), 64'hAAAA);
        chk("flush_lo", 64'(bus.lo), 64'h5555);

        // start and mthi while busy are ignored
        launch(2'b00, 32'd6, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.srca  = 32'd100;
        bus.srcb  = 32'd7;
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        chk("busy_mthi", 64'(bus.hi), 64'hAAAA);
        wait_done(lat, bcnt);
        chk("intf_hi", 64'(bus.hi), 64'd0);
        chk("intf_lo", 64'(bus.lo), 64'd42);
        @(posedge clk);
        #1;
        chk("intf_idle", 64'(bus.busy), 64'd0);

        // asynchronous reset mid-RUN, observed before any clock edge
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_hi",   64'(bus.hi),   64'd0);
        chk("arst_lo",   64'(bus.lo),   64'd0);
        @(negedge clk);
        reset = 1'b0;

        // start and mtlo together: op runs, LO write dropped
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.srca  = 32'd100;
        bus.srcb  = 32'd7;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h77;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        chk("smtlo_lo",   64'(bus.lo),   64'd0);
        chk("smtlo_busy", 64'(bus.busy), 64'd1);
        wait_done(lat, bcnt);
        chk("smtlo_rhi", 64'(bus.hi), 64'd2);
        chk("smtlo_rlo", 64'(bus.lo), 64'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, attached beside the EX stage of the pipelined MIPS core. It accepts one operation per `start` pulse and computes it iteratively, one bit per cycle, over `WIDTH` cycles. While it works it raises `busy`, which the hazard logic uses to stall `mfhi`/`mflo`/new mul-div instructions. It also supports `mthi`/`mtlo` writes and pipeline-flush abort.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4.
- `CNTW`, $clog2(WIDTH+1): iteration counter width.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: launch operation; sampled only in IDLE.
- `op` input 2: 00 multu, 01 mult, 10 divu, 11 div.
- `srca` input WIDTH: multiplicand / dividend.
- `srcb` input WIDTH: multiplier / divisor.
- `flush` input 1: abort an in-progress operation.
- `mthi` input 1: write `wdata` to HI.
- `mtlo` input 1: write `wdata` to LO.
- `wdata` input WIDTH: data for `mthi`/`mtlo`.
- `busy` output 1: high in RUN and FIN states.
- `done` output 1: one-cycle pulse when HI/LO are updated by an operation.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: `WIDTH` iterations, counted by `cnt`.
  - FIN: sign fix-up and result commit.
- IDLE with `start`=1 → RUN:
  - latch magnitudes of the operands (abs value when signed op), the operand signs, and `op`;
  - `cnt` ← 0;
  - accumulator ← 0.
- RUN, one iteration per cycle:
  - multiply: shift-add over a 2·WIDTH-bit product;
  - divide: restoring shift-subtract, quotient bit set when the trial remainder ≥ divisor.
  - When `cnt` = WIDTH−1 → FIN; otherwise `cnt` ← `cnt`+1.
- FIN → IDLE. On this edge:
  - write HI/LO: multiply gives HI = upper half, LO = lower half; divide gives LO = quotient, HI = remainder;
  - `done` = 1 for the following cycle.
- Signed fix-up:
  - product negated if sign(a)^sign(b);
  - quotient negated if sign(a)^sign(b);
  - remainder takes the sign of `srca`.
- All arithmetic is modulo 2^WIDTH per half.
- Divide by zero (any mode): LO = all ones, HI = original `srca`. No exception is raised.
- Signed overflow (MIN / −1): LO = MIN, HI = 0.
- `start` while `busy`: ignored, no queueing.
- `flush` in RUN or FIN: → IDLE next edge. HI/LO are unchanged and `done` stays 0. `flush` in IDLE has no effect, and also suppresses a `start` sampled in the same cycle.
- `mthi`/`mtlo` act only in IDLE and only when `start`=0. If `start` is also high, `start` wins and the write is dropped. While `busy`, the writes are ignored.
- `mthi` and `mtlo` may both be asserted in one cycle; both registers then take `wdata`.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, `cnt` = 0.
- Reset mid-operation returns immediately to these values.
- Start edge E0:
  - `busy` = 1 from after E0 through the cycle preceding E(WIDTH+1);
  - E1..E(WIDTH) are the iterations;
  - E(WIDTH+1) commits HI/LO, `busy` → 0, `done` → 1 for one cycle.
- Earliest next `start`: sampled at E(WIDTH+1)'s following edge. The cycle where `done` = 1 is IDLE and may carry a new `start`.
- `hi`/`lo` are registered outputs, with no combinational path from inputs.
- `busy` is decoded from the registered state only.

## Configuration
- `MULDIV_SIGNED_EN` defined: `op[0]` selects signed mult/div. Abs-value input conditioning and sign fix-up logic are compiled in.
- Not defined: `op[0]` is ignored. All operations execute as multu/divu and the sign logic is absent. Latency is identical.

## Test plan
(WIDTH=32, `MULDIV_SIGNED_EN` defined unless noted)
- multu 0xFFFFFFFF × 0xFFFFFFFF → `done` 33 cycles after start edge; `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `busy` high for exactly 33 cycles.
- mult 0xFFFFFFFD (−3) × 5 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1. Without the macro, the same op gives `hi` = 0x00000004, `lo` = 0xFFFFFFF1.
- divu 100 / 7 → `lo` = 14, `hi` = 2. Then div 0xFFFFFFF9 (−7) / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- divu 0x1234 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x1234.
- Preload with mthi = 0xAAAA and mtlo = 0x5555, start multu 3×3, assert `flush` at iteration 10 → `busy` low next cycle, no `done`, `hi`/`lo` remain 0xAAAA/0x5555.
- Interference during an operation:
  - `start` and `mthi` pulsed while busy → ignored; result of the first op only.
  - async `reset` mid-RUN → all outputs 0 without a clock edge.
  - `start` + `mtlo` in the same IDLE cycle → op runs, LO write dropped.
